// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ID-stage issue/stall control with register scoreboard and halt drain
module pipe_hazard_ctrl #(
  parameter int NREG = 32,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_ir,
  input  logic             id_wr,
  input  logic             id_rd_use,
  input  logic             wb_valid,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  output logic             pc_en,
  output logic             id_stall,
  output logic             ex_bubble,
  output logic             issue,
  output logic             halted,
  output logic [CNT_W-1:0] inflight,
  output logic [NREG-1:0]  busy
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, state_nxt;
  logic [5:0] op;
  logic [4:0] rd, rs1, rs2;
  logic [NREG-1:0] wb_clr, id_set, eff_busy, busy_nxt;
  logic [CNT_W-1:0] inflight_nxt;
  logic hazard, is_hlt, run, inc, dec, unused_ir;
  assign op = id_ir[31:26];
  assign rd = id_ir[25:21];
  assign rs1 = id_ir[20:16];
  assign rs2 = id_ir[15:11];
  assign unused_ir = ^id_ir[10:0];
  // Write-through view: a same-cycle writeback already resolves its hazard
  always_comb begin
    wb_clr = (wb_valid & wb_we) ? (NREG'(1) << wb_rd) : '0;
    eff_busy = busy & ~wb_clr;
    is_hlt = id_valid & (op == 6'b111111);
    hazard = eff_busy[rs1] | eff_busy[rs2] | ((id_rd_use | id_wr) & eff_busy[rd]) |
             ((inflight == CNT_W'(PIPE_DEPTH)) & ~wb_valid);
    run = (state == RUN);
    issue = run & id_valid & ~hazard;
    id_stall = run ? (id_valid & hazard) : 1'b1;
    pc_en = ~id_stall;
    ex_bubble = ~issue | is_hlt;
    halted = (state == HALTED);
  end
  // Next scoreboard, in-flight count and sequencing state
  always_comb begin
    inc = issue & ~is_hlt;
    dec = wb_valid & (inflight != '0);
    inflight_nxt = inflight + CNT_W'(inc) - CNT_W'(dec);
    id_set = (inc & id_wr & (rd != 5'd0)) ? (NREG'(1) << rd) : '0;
    busy_nxt = (eff_busy | id_set) & ~NREG'(1);
    state_nxt = (state == RUN) ? ((issue & is_hlt) ? DRAIN : RUN) :
                (state == DRAIN) ? ((inflight_nxt == '0) ? HALTED : DRAIN) : HALTED;
  end
  // Register update; retirement is honoured in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      busy <= '0;
      inflight <= '0;
    end else begin
      state <= state_nxt;
      busy <= busy_nxt;
      inflight <= inflight_nxt;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of issue/stall, scoreboard, capacity and halt
module tb_pipe_hazard_ctrl;
  logic clk = 0, rst = 1;
  logic id_valid = 0, id_wr = 0, id_rd_use = 0, wb_valid = 0, wb_we = 0;
  logic [31:0] id_ir = 0;
  logic [4:0] wb_rd = 0;
  logic pc_en, id_stall, ex_bubble, issue, halted;
  logic [1:0] inflight;
  logic [31:0] busy;
  int checks = 0, errors = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ir(id_ir), .id_wr(id_wr),
    .id_rd_use(id_rd_use), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .pc_en(pc_en), .id_stall(id_stall), .ex_bubble(ex_bubble), .issue(issue),
    .halted(halted), .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic wr,
                        input logic ru);
    id_valid = v;
    id_ir = {op, rd, rs1, rs2, 11'd0};
    id_wr = wr;
    id_rd_use = ru;
    #1;
  endtask

  task automatic set_wb(input logic v, input logic we, input logic [4:0] rd);
    wb_valid = v;
    wb_we = we;
    wb_rd = rd;
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    tick();
    tick();
    rst = 0;
    #1;
    checks++;
    if ({pc_en, id_stall, ex_bubble, issue, halted} !== 5'b10100) begin
      errors++; $display("FAIL reset_ctl got %b exp %b", {pc_en, id_stall, ex_bubble, issue, halted}, 5'b10100);
    end
    checks++;
    if (busy !== 32'h0 || inflight !== 2'd0) begin
      errors++; $display("FAIL reset_regs got busy=%h inflight=%0d exp busy=0 inflight=0", busy, inflight);
    end
  endtask

  task automatic test_r0();
    set_id(1, 0, 0, 0, 0, 1, 0);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL r0_write_issue got %b exp 1", issue); end
    tick();
    checks++;
    if (busy !== 32'h0 || inflight !== 2'd1) begin
      errors++; $display("FAIL r0_busy got busy=%h inflight=%0d exp busy=0 inflight=1", busy, inflight);
    end
    set_id(1, 0, 1, 0, 0, 0, 0);
    checks++;
    if ({issue, id_stall} !== 2'b10) begin errors++; $display("FAIL r0_read got %b exp 10", {issue, id_stall}); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 0, 0);
    tick();
    tick();
    set_wb(0, 0, 0);
    checks++;
    if (inflight !== 2'd0) begin errors++; $display("FAIL r0_drain got %0d exp 0", inflight); end
  endtask

  task automatic test_raw();
    set_id(1, 0, 3, 0, 0, 1, 0);
    tick();
    checks++;
    if (busy !== 32'h8 || inflight !== 2'd1) begin
      errors++; $display("FAIL raw_set got busy=%h inflight=%0d exp busy=8 inflight=1", busy, inflight);
    end
    set_id(1, 0, 1, 3, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({pc_en, id_stall, ex_bubble, issue} !== 4'b0110) begin
        errors++; $display("FAIL raw_stall%0d got %b exp 0110", i, {pc_en, id_stall, ex_bubble, issue});
      end
      tick();
    end
    set_wb(1, 1, 3);
    checks++;
    if ({pc_en, id_stall, ex_bubble, issue} !== 4'b1001) begin
      errors++; $display("FAIL raw_release got %b exp 1001", {pc_en, id_stall, ex_bubble, issue});
    end
    tick();
    checks++;
    if (busy !== 32'h0 || inflight !== 2'd1) begin
      errors++; $display("FAIL raw_after got busy=%h inflight=%0d exp busy=0 inflight=1", busy, inflight);
    end
    set_id(1, 0, 2, 0, 0, 0, 1);
    set_wb(0, 0, 0);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL rduse_free got %b exp 1", issue); end
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 0, 0);
    tick();
    set_wb(0, 0, 0);
    checks++;
    if (inflight !== 2'd0) begin errors++; $display("FAIL raw_drain got %0d exp 0", inflight); end
  endtask

  task automatic test_set_clear();
    set_id(1, 0, 5, 0, 0, 1, 0);
    tick();
    set_id(1, 0, 6, 0, 0, 0, 1);
    set_wb(0, 0, 0);
    checks++;
    if (id_stall !== 1'b0) begin errors++; $display("FAIL rduse_other got %b exp 0", id_stall); end
    set_id(1, 0, 5, 0, 0, 0, 1);
    checks++;
    if (id_stall !== 1'b1) begin errors++; $display("FAIL rduse_hazard got %b exp 1", id_stall); end
    set_id(1, 0, 5, 0, 0, 1, 0);
    checks++;
    if (id_stall !== 1'b1) begin errors++; $display("FAIL waw_hazard got %b exp 1", id_stall); end
    set_wb(1, 1, 5);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL setclr_issue got %b exp 1", issue); end
    tick();
    checks++;
    if (busy !== 32'h20 || inflight !== 2'd1) begin
      errors++; $display("FAIL setclr_after got busy=%h inflight=%0d exp busy=20 inflight=1", busy, inflight);
    end
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    set_wb(0, 0, 0);
    checks++;
    if (busy !== 32'h0 || inflight !== 2'd0) begin
      errors++; $display("FAIL setclr_drain got busy=%h inflight=%0d exp busy=0 inflight=0", busy, inflight);
    end
  endtask

  task automatic test_capacity();
    set_id(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    checks++;
    if (inflight !== 2'd3) begin errors++; $display("FAIL cap_full got %0d exp 3", inflight); end
    checks++;
    if ({pc_en, id_stall, ex_bubble, issue} !== 4'b0110) begin
      errors++; $display("FAIL cap_stall got %b exp 0110", {pc_en, id_stall, ex_bubble, issue});
    end
    tick();
    checks++;
    if (inflight !== 2'd3) begin errors++; $display("FAIL cap_hold got %0d exp 3", inflight); end
    set_wb(1, 0, 0);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL cap_wb_issue got %b exp 1", issue); end
    tick();
    checks++;
    if (inflight !== 2'd3) begin errors++; $display("FAIL cap_swap got %0d exp 3", inflight); end
    set_id(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (inflight !== 2'd0) begin errors++; $display("FAIL cap_saturate got %0d exp 0", inflight); end
    set_wb(0, 0, 0);
  endtask

  task automatic test_halt();
    set_id(1, 0, 1, 0, 0, 1, 0);
    tick();
    set_id(1, 0, 2, 0, 0, 1, 0);
    tick();
    set_id(1, 6'h3f, 0, 0, 0, 0, 0);
    checks++;
    if ({pc_en, ex_bubble, issue} !== 3'b111) begin
      errors++; $display("FAIL halt_issue got %b exp 111", {pc_en, ex_bubble, issue});
    end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({pc_en, id_stall, ex_bubble, issue, halted} !== 5'b01100) begin
      errors++; $display("FAIL drain_ctl got %b exp 01100", {pc_en, id_stall, ex_bubble, issue, halted});
    end
    checks++;
    if (busy !== 32'h6 || inflight !== 2'd2) begin
      errors++; $display("FAIL drain_regs got busy=%h inflight=%0d exp busy=6 inflight=2", busy, inflight);
    end
    set_wb(1, 1, 1);
    tick();
    set_wb(1, 1, 2);
    tick();
    set_wb(0, 0, 0);
    checks++;
    if (busy !== 32'h0 || inflight !== 2'd0 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_timing got busy=%h inflight=%0d halted=%b exp 0 0 1", busy, inflight, halted);
    end
    set_id(1, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if ({pc_en, id_stall, issue, halted} !== 4'b0101) begin
      errors++; $display("FAIL halt_sticky got %b exp 0101", {pc_en, id_stall, issue, halted});
    end
    set_id(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_drain();
    rst = 1;
    tick();
    rst = 0;
    set_id(1, 0, 4, 0, 0, 1, 0);
    tick();
    set_id(1, 6'h3f, 0, 0, 0, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pc_en !== 1'b0 || busy !== 32'h10) begin
      errors++; $display("FAIL rstdrain_pre got pc_en=%b busy=%h exp 0 10", pc_en, busy);
    end
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++;
    if ({pc_en, id_stall, halted} !== 3'b100 || busy !== 32'h0 || inflight !== 2'd0) begin
      errors++; $display("FAIL rstdrain_post got ctl=%b busy=%h inflight=%0d exp 100 0 0", {pc_en, id_stall, halted}, busy, inflight);
    end
    set_id(1, 0, 7, 0, 0, 1, 0);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL rstdrain_run got %b exp 1", issue); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_r0();
    test_raw();
    test_set_clear();
    test_capacity();
    test_halt();
    test_reset_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
